// File: rtl/cic_pkg.sv
// Shared constants and elaboration helpers for the CIC integrator/comb chain.
// Used by cic_integ_decim (optional CIC_INTEG_RATE_LOAD_EN rate port) and its integrator stages.
package cic_pkg;

    localparam int CIC_STAGES_MAX = 8;
    localparam int CIC_RATE_MAX   = 8192;

    // Ceiling log2; clog2(1) is 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                result = i + 32'sd1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

    // Minimum accumulator width that cannot lose information for the largest ratio.
    function automatic int acc_width(input int in_w, input int stages, input int rate_max);
        return in_w + stages * clog2(rate_max);
    endfunction

    // Width of the runtime rate port, shared with the comb chain and its wrapper.
    localparam int CIC_RATE_W = clog2(CIC_RATE_MAX + 1);

endpackage

// File: rtl/cic_integrator.sv
// One CIC integrator stage: a modulo-2^WIDTH accumulator advanced on strobe.
// Mirrors the per-stage comb module of the downstream chain.
module cic_integrator
    import cic_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             strobe,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] out_data
);

    // Accumulate on strobe; overflow wraps, which the comb section relies on.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_data <= {WIDTH{1'b0}};
        end else if (strobe) begin
            out_data <= out_data + in_data;
        end else begin
            out_data <= out_data;
        end
    end

endmodule

// File: rtl/cic_integ_decim.sv
// Integrate-and-decimate half of the CIC decimator: STAGES integrators plus a 1-in-R output strobe.
// Define CIC_INTEG_RATE_LOAD_EN to add a runtime rate port latched at frame boundaries.
module cic_integ_decim
    import cic_pkg::*;
#(
    parameter int STAGES    = 5,
    parameter int IN_WIDTH  = 24,
    parameter int ACC_WIDTH = 64,
    parameter int RATE_MAX  = 8192,
    parameter int RATE      = 256
) (
    input  logic                           clock,
    input  logic                           reset,
`ifdef CIC_INTEG_RATE_LOAD_EN
    input  logic [clog2(RATE_MAX + 1)-1:0] rate,
`endif
    input  logic                           in_strobe,
    input  logic [IN_WIDTH-1:0]            in_data,
    output logic                           out_strobe,
    output logic [ACC_WIDTH-1:0]           out_data
);

    localparam int CNT_W  = (clog2(RATE_MAX) > 0) ? clog2(RATE_MAX) : 1;
    localparam int RATE_W = clog2(RATE_MAX + 1);

    if (STAGES < 1 || STAGES > CIC_STAGES_MAX) begin : g_bad_stages
        $error("cic_integ_decim: STAGES must be in 1..%0d", CIC_STAGES_MAX);
    end
    if (RATE_MAX < 1) begin : g_bad_rate_max
        $error("cic_integ_decim: RATE_MAX must be at least 1");
    end
    if (ACC_WIDTH < acc_width(IN_WIDTH, STAGES, RATE_MAX)) begin : g_bad_acc
        $error("cic_integ_decim: ACC_WIDTH too small for IN_WIDTH/STAGES/RATE_MAX");
    end

    logic [ACC_WIDTH-1:0] sample_ext_s;
    logic [ACC_WIDTH-1:0] integ_s [STAGES];
    logic [CNT_W-1:0]     cnt_r;
    logic [CNT_W-1:0]     last_s;
    logic                 wrap_s;

    assign sample_ext_s = ACC_WIDTH'(signed'(in_data));

    // Pipelined chain: each stage adds the previous stage's registered (pre-update) value.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [ACC_WIDTH-1:0] addend_s;
        if (k == 0) begin : g_first
            assign addend_s = sample_ext_s;
        end else begin : g_next
            assign addend_s = integ_s[k-1];
        end
        cic_integrator #(
            .WIDTH (ACC_WIDTH)
        ) u_integ (
            .clock    (clock),
            .reset    (reset),
            .strobe   (in_strobe),
            .in_data  (addend_s),
            .out_data (integ_s[k])
        );
    end

`ifdef CIC_INTEG_RATE_LOAD_EN
    logic [CNT_W-1:0] last_r;

    // Map a requested ratio to the terminal count: 0 and 1 mean R = 1, large values clamp.
    function automatic logic [CNT_W-1:0] rate_to_last(input logic [RATE_W-1:0] value);
        logic [CNT_W-1:0] result;
        if (value <= RATE_W'(1)) begin
            result = {CNT_W{1'b0}};
        end else if (value > RATE_W'(RATE_MAX)) begin
            result = CNT_W'(RATE_MAX - 1);
        end else begin
            result = CNT_W'(value - RATE_W'(1));
        end
        return result;
    endfunction

    // Ratio is sampled only in reset and at a frame boundary so a frame is never truncated.
    always_ff @(posedge clock) begin
        if (reset) begin
            last_r <= rate_to_last(rate);
        end else if (wrap_s) begin
            last_r <= rate_to_last(rate);
        end else begin
            last_r <= last_r;
        end
    end

    assign last_s = last_r;
`else
    if (RATE < 1 || RATE > RATE_MAX) begin : g_bad_rate
        $error("cic_integ_decim: RATE must be in 1..RATE_MAX");
    end

    localparam logic [CNT_W-1:0] LAST = CNT_W'(RATE - 1);

    assign last_s = LAST;
`endif

    assign wrap_s = in_strobe && (cnt_r == last_s);

    // Decimation counter: counts accepted samples within the current frame.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (wrap_s) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (in_strobe) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Output tap takes the last integrator before this cycle's update; data holds between strobes.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_strobe <= 1'b0;
            out_data   <= {ACC_WIDTH{1'b0}};
        end else if (wrap_s) begin
            out_strobe <= 1'b1;
            out_data   <= integ_s[STAGES-1];
        end else begin
            out_strobe <= 1'b0;
            out_data   <= out_data;
        end
    end

endmodule

// File: tb/tb_cic_integ_decim.sv
// Self-checking bench for cic_integ_decim: two configurations against a behavioural model,
// plus literal DC, impulse and full-scale wrap expectations.
module tb_cic_integ_decim;

    localparam int A_STAGES = 1;
    localparam int A_ACC    = 12;
    localparam int A_RMAX   = 16;
    localparam int A_RATE   = 4;
    localparam int B_STAGES = 5;
    localparam int B_ACC    = 24;
    localparam int B_RMAX   = 8;
    localparam int B_RATE   = 8;

    typedef struct packed {
        logic [7:0][63:0] integ;
        logic [31:0]      cnt;
        logic [31:0]      r;
        logic             stb;
        logic [63:0]      data;
    } model_t;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             stb_a = 1'b0;
    logic             stb_b = 1'b0;
    logic [7:0]       x_a = 8'd0;
    logic [7:0]       x_b = 8'd0;
    logic [4:0]       rate_a = 5'(A_RATE);
    logic [3:0]       rate_b = 4'(B_RATE);
    logic             ostb_a;
    logic             ostb_b;
    logic [A_ACC-1:0] odata_a;
    logic [B_ACC-1:0] odata_b;

    int     checks = 0;
    int     errors = 0;
    bit     chk_en = 1'b0;
    model_t ma = '0;
    model_t mb = '0;
    logic [63:0] cap_a[$];
    logic [63:0] cap_b[$];
    logic [63:0] mcap_a[$];
    logic [63:0] mcap_b[$];

    always #5 clock = ~clock;

    cic_integ_decim #(
        .STAGES(A_STAGES), .IN_WIDTH(8), .ACC_WIDTH(A_ACC), .RATE_MAX(A_RMAX), .RATE(A_RATE)
    ) u_dut_a (
        .clock      (clock),
        .reset      (reset),
`ifdef CIC_INTEG_RATE_LOAD_EN
        .rate       (rate_a),
`endif
        .in_strobe  (stb_a),
        .in_data    (x_a),
        .out_strobe (ostb_a),
        .out_data   (odata_a)
    );

    cic_integ_decim #(
        .STAGES(B_STAGES), .IN_WIDTH(8), .ACC_WIDTH(B_ACC), .RATE_MAX(B_RMAX), .RATE(B_RATE)
    ) u_dut_b (
        .clock      (clock),
        .reset      (reset),
`ifdef CIC_INTEG_RATE_LOAD_EN
        .rate       (rate_b),
`endif
        .in_strobe  (stb_b),
        .in_data    (x_b),
        .out_strobe (ostb_b),
        .out_data   (odata_b)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int eff_r(input int req, input int rmax);
        if (req <= 1) return 1;
        if (req > rmax) return rmax;
        return req;
    endfunction

    // Spec-level model: R-sample frames; every stage sums its own value with the stage
    // before it (or the new sample) using the values from before this strobe.
    function automatic model_t model_next(input model_t m, input logic rst, input logic stb,
                                          input logic [7:0] x, input int s, input int w,
                                          input int r_next);
        model_t      n;
        logic [63:0] mask;
        logic [63:0] sx;
        mask = (64'd1 << w) - 64'd1;
        sx   = {{56{x[7]}}, x};
        n    = m;
        if (rst) begin
            n   = '0;
            n.r = r_next;
        end else begin
            n.stb = 1'b0;
            if (stb) begin
                if (m.cnt == m.r - 1) begin
                    n.data = m.integ[s-1];
                    n.stb  = 1'b1;
                    n.cnt  = 0;
                    n.r    = r_next;
                end else begin
                    n.cnt = m.cnt + 1;
                end
                for (int k = 0; k < s; k++) begin
                    n.integ[k] = (m.integ[k] + ((k == 0) ? sx : m.integ[k-1])) & mask;
                end
            end
        end
        return n;
    endfunction

    // Model advances on the same edge as the DUT using the inputs presented to it.
    always @(posedge clock) begin
`ifdef CIC_INTEG_RATE_LOAD_EN
        ma <= model_next(ma, reset, stb_a, x_a, A_STAGES, A_ACC, eff_r(int'(rate_a), A_RMAX));
        mb <= model_next(mb, reset, stb_b, x_b, B_STAGES, B_ACC, eff_r(int'(rate_b), B_RMAX));
`else
        ma <= model_next(ma, reset, stb_a, x_a, A_STAGES, A_ACC, A_RATE);
        mb <= model_next(mb, reset, stb_b, x_b, B_STAGES, B_ACC, B_RATE);
`endif
    end

    // Compare every cycle on the falling edge; collect strobed values for the literal pins.
    always @(negedge clock) begin
        if (chk_en) begin
            check("a_strobe", 64'(ostb_a), 64'(ma.stb));
            check("a_data", 64'(odata_a), ma.data);
            check("b_strobe", 64'(ostb_b), 64'(mb.stb));
            check("b_data", 64'(odata_b), mb.data);
            if (ostb_a === 1'b1) cap_a.push_back(64'(odata_a));
            if (ostb_b === 1'b1) cap_b.push_back(64'(odata_b));
            if (ma.stb) mcap_a.push_back(ma.data);
            if (mb.stb) mcap_b.push_back(mb.data);
        end
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic clear_caps();
        cap_a.delete();
        cap_b.delete();
        mcap_a.delete();
        mcap_b.delete();
    endtask

    function automatic logic [63:0] qget(input logic [63:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 64'hDEAD_DEAD_DEAD_DEAD;
    endfunction

    initial begin
        int mode;
        logic [63:0] dc_exp [4];
        logic [63:0] imp_exp [3];
        dc_exp  = '{64'd3, 64'd7, 64'd11, 64'd15};
        imp_exp = '{64'd15, 64'd1001, 64'd7315};

        tick();
        chk_en = 1'b1;
        tick();
        tick();
        check("reset_a_strobe", 64'(ostb_a), 64'd0);
        check("reset_a_data", 64'(odata_a), 64'd0);
        check("reset_b_strobe", 64'(ostb_b), 64'd0);
        check("reset_b_data", 64'(odata_b), 64'd0);
        reset = 1'b0;
        clear_caps();

        // DC 1 into the single-stage instance, unit impulse into the five-stage one.
        for (int i = 0; i < 26; i++) begin
            stb_a = 1'b1;
            stb_b = 1'b1;
            x_a   = 8'd1;
            x_b   = (i == 0) ? 8'd1 : 8'd0;
            tick();
        end
        stb_a = 1'b0;
        stb_b = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("dc_dut_%0d", i), qget(cap_a, i), dc_exp[i]);
            check($sformatf("dc_model_%0d", i), qget(mcap_a, i), dc_exp[i]);
        end
        for (int i = 0; i < 3; i++) begin
            check($sformatf("impulse_dut_%0d", i), qget(cap_b, i), imp_exp[i]);
            check($sformatf("impulse_model_%0d", i), qget(mcap_b, i), imp_exp[i]);
        end

        // Full-scale negative input after a reset: integrators wrap modulo 2^ACC.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        clear_caps();
        for (int i = 0; i < 10; i++) begin
            stb_a = 1'b1;
            stb_b = 1'b1;
            x_a   = 8'h80;
            x_b   = 8'h80;
            tick();
        end
        stb_a = 1'b0;
        stb_b = 1'b0;
        tick();
        tick();
        check("wrap_a_dut_0", qget(cap_a, 0), 64'd3712);
        check("wrap_a_dut_1", qget(cap_a, 1), 64'd3200);
        check("wrap_b_dut_0", qget(cap_b, 0), 64'd16774528);
        check("wrap_a_model_0", qget(mcap_a, 0), 64'd3712);
        check("wrap_b_model_0", qget(mcap_b, 0), 64'd16774528);

        // Randomized blocks: full rate, 1-in-3 duty, random duty, held full-scale input.
        for (int blk = 0; blk < 32; blk++) begin
            mode = int'($urandom_range(0, 3));
            for (int i = 0; i < 100; i++) begin
                reset = ($urandom_range(0, 299) == 0);
                case (mode)
                    0: begin stb_a = 1'b1; stb_b = 1'b1; end
                    1: begin stb_a = (i % 3 == 0); stb_b = (i % 3 == 0); end
                    default: begin stb_a = 1'($urandom); stb_b = 1'($urandom); end
                endcase
                if (mode == 3) begin
                    x_a = 8'h80;
                    x_b = 8'h80;
                end else begin
                    x_a = ($urandom_range(0, 7) == 0) ? 8'h80 : 8'($urandom);
                    x_b = ($urandom_range(0, 7) == 0) ? 8'h7F : 8'($urandom);
                end
`ifdef CIC_INTEG_RATE_LOAD_EN
                if ($urandom_range(0, 40) == 0) rate_a = 5'($urandom);
                if ($urandom_range(0, 40) == 0) rate_b = 4'($urandom);
`endif
                tick();
            end
        end
        reset = 1'b0;
        stb_a = 1'b0;
        stb_b = 1'b0;
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
